// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, ALU source codes and
// operand forwarding selects used by the EX-stage control logic.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2
  } src2_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_e;

  // x0 never produces a value worth forwarding.
  function automatic logic reg_hit(
    input logic [REG_W-1:0] idx,
    input logic             used,
    input logic [REG_W-1:0] rd,
    input logic             wen
  );
    return used && wen && (rd != REG_X0) && (rd == idx);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one ID source index against the EX/MEM/WB producer entries and
// returns the operand select the consumer will need once it reaches EX.
module fwd_match
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] idx,
  input  logic             used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wen,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wen,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wen,
  output logic [1:0]       sel,
  output logic             load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit   = reg_hit(idx, used, ex_rd, ex_wen);
  assign mem_hit  = reg_hit(idx, used, mem_rd, mem_wen);
  assign wb_hit   = reg_hit(idx, used, wb_rd, wb_wen);
  assign load_hit = ex_hit && ex_load;

  // NOTE: sel gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_MEM;  // younger producer wins
    else if (mem_hit) sel = FWD_WB;
    else if (wb_hit)  sel = FWD_RF;   // regfile writes before it is read
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage operand control: tracks in-flight destinations, registers
// forwarding selects computed in ID, and inserts load-use bubbles.
module hazard_forward_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [1:0]       id_alu_src1,
  input  logic [1:0]       id_alu_src2,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             stall,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_src1,
  output logic [1:0]       ex_alu_src2,
  output logic [1:0]       ex_fwd1,
  output logic [1:0]       ex_fwd2,
  output logic [31:0]      stall_cnt
);

  logic [REG_W-1:0] ex_rd,  mem_rd, wb_rd;
  logic             ex_wen, mem_wen, wb_wen;
  logic             ex_load, mem_load;

  logic [1:0] fwd1_raw, fwd2;
  logic [1:0] fwd1;
  logic       load_hit1, load_hit2;
  logic       load_use;
  logic       bubble;

  fwd_match u_match_rs1 (
    .idx      (id_rs1),
    .used     (id_rs1_used),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .ex_load  (ex_load),
    .mem_rd   (mem_rd),
    .mem_wen  (mem_wen),
    .wb_rd    (wb_rd),
    .wb_wen   (wb_wen),
    .sel      (fwd1_raw),
    .load_hit (load_hit1)
  );

  fwd_match u_match_rs2 (
    .idx      (id_rs2),
    .used     (id_rs2_used),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .ex_load  (ex_load),
    .mem_rd   (mem_rd),
    .mem_wen  (mem_wen),
    .wb_rd    (wb_rd),
    .wb_wen   (wb_wen),
    .sel      (fwd2),
    .load_hit (load_hit2)
  );

  // rs2 also carries store data, so only the rs1 path honours its source code.
  assign fwd1     = (id_alu_src1 == SRC1_RS1) ? fwd1_raw : FWD_RF;
  assign load_use = id_valid && (load_hit1 || load_hit2);
  assign bubble   = ex_redirect || load_use;
  assign stall    = mem_stall || (load_use && !ex_redirect);

  // NOTE: the reset is synchronous, so it sits inside the clocked block and is sampled on clk.
  // NOTE: state updates use <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rd       <= REG_X0;
      ex_wen      <= 1'b0;
      ex_load     <= 1'b0;
      ex_fwd1     <= FWD_RF;
      ex_fwd2     <= FWD_RF;
      ex_alu_src1 <= SRC1_RS1;
      ex_alu_src2 <= SRC2_RS2;
      mem_rd      <= REG_X0;
      mem_wen     <= 1'b0;
      mem_load    <= 1'b0;
      wb_rd       <= REG_X0;
      wb_wen      <= 1'b0;
      stall_cnt   <= '0;
    end else if (!mem_stall) begin
      mem_rd   <= ex_rd;
      mem_wen  <= ex_wen;
      mem_load <= ex_load;
      wb_rd    <= mem_rd;
      wb_wen   <= mem_wen;

      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_rd       <= REG_X0;
        ex_wen      <= 1'b0;
        ex_load     <= 1'b0;
        ex_fwd1     <= FWD_RF;
        ex_fwd2     <= FWD_RF;
        ex_alu_src1 <= SRC1_RS1;
        ex_alu_src2 <= SRC2_RS2;
      end else begin
        ex_valid    <= id_valid;
        ex_rd       <= id_rd;
        ex_wen      <= id_valid && id_reg_write;
        ex_load     <= id_valid && id_mem_read;
        ex_fwd1     <= fwd1;
        ex_fwd2     <= fwd2;
        ex_alu_src1 <= id_alu_src1;
        ex_alu_src2 <= id_alu_src2;
      end

      // A redirect kills the consumer, so its pending hazard is not counted.
      if (load_use && !ex_redirect) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // mem_load only mirrors the stage for debug visibility; nothing downstream reads it.
  logic unused_ok;
  assign unused_ok = mem_load;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: hand-derived expected EX-stage outputs are queued when
// each ID instruction is driven and compared after the following clock edge.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic [1:0] src1;
    logic [1:0] src2;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  fwd1;
    logic [1:0]  fwd2;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic [1:0]  id_alu_src1 = '0, id_alu_src2 = '0;
  logic        ex_redirect = 1'b0, mem_stall = 1'b0;
  logic        stall, ex_valid;
  logic [1:0]  ex_alu_src1, ex_alu_src2, ex_fwd1, ex_fwd2;
  logic [31:0] stall_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .id_alu_src1 (id_alu_src1),
    .id_alu_src2 (id_alu_src2),
    .ex_redirect (ex_redirect),
    .mem_stall   (mem_stall),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_alu_src1 (ex_alu_src1),
    .ex_alu_src2 (ex_alu_src2),
    .ex_fwd1     (ex_fwd1),
    .ex_fwd2     (ex_fwd2),
    .stall_cnt   (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic [1:0] s1, input logic [1:0] s2);
    return '{v, rs1, u1, rs2, u2, rd, rw, mr, s1, s2};
  endfunction

  function automatic exp_t ex(input logic v, input logic [1:0] f1, input logic [1:0] f2,
                              input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] c);
    return '{v, f1, f2, s1, s2, c};
  endfunction

  // One pipeline cycle: drive ID at the falling edge, check comb stall,
  // queue the expected EX state, then compare it just after the rising edge.
  task automatic step(input string tag, input instr_t ins,
                      input logic redir, input logic ms, input logic rs,
                      input logic chk_stall, input logic exp_stall, input exp_t e);
    exp_t got;
    @(negedge clk);
    id_valid     = ins.valid;
    id_rs1       = ins.rs1;
    id_rs1_used  = ins.rs1_used;
    id_rs2       = ins.rs2;
    id_rs2_used  = ins.rs2_used;
    id_rd        = ins.rd;
    id_reg_write = ins.reg_write;
    id_mem_read  = ins.mem_read;
    id_alu_src1  = ins.src1;
    id_alu_src2  = ins.src2;
    ex_redirect  = redir;
    mem_stall    = ms;
    rst          = rs;
    #1;
    if (chk_stall) check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check({tag, ".ex_valid"},  {31'd0, ex_valid},    {31'd0, got.valid});
      check({tag, ".ex_fwd1"},   {30'd0, ex_fwd1},     {30'd0, got.fwd1});
      check({tag, ".ex_fwd2"},   {30'd0, ex_fwd2},     {30'd0, got.fwd2});
      check({tag, ".ex_src1"},   {30'd0, ex_alu_src1}, {30'd0, got.src1});
      check({tag, ".ex_src2"},   {30'd0, ex_alu_src2}, {30'd0, got.src2});
      check({tag, ".stall_cnt"}, stall_cnt,            got.cnt);
    end
  endtask

  instr_t nop;

  initial begin
    nop = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.ex_valid",  {31'd0, ex_valid},    32'd0);
    check("reset.ex_fwd1",   {30'd0, ex_fwd1},     32'd0);
    check("reset.ex_fwd2",   {30'd0, ex_fwd2},     32'd0);
    check("reset.ex_src1",   {30'd0, ex_alu_src1}, 32'd0);
    check("reset.ex_src2",   {30'd0, ex_alu_src2}, 32'd0);
    check("reset.stall_cnt", stall_cnt,            32'd0);
    check("reset.stall",     {31'd0, stall},       32'd0);

    // Back-to-back producer/consumer, then one and two producers of x5 in flight.
    step("a_add_x5",  mk(1, 1,1, 2,1,  5,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("b_use_ex",  mk(1, 5,1, 6,1,  8,1,0, 0,0), 0,0,0, 1,0, ex(1,1,0,0,0,0));
    step("c_add_x5",  mk(1, 1,1, 2,1,  5,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("d_indep",   mk(1, 3,1, 4,1,  9,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("e_use_mem", mk(1, 5,1, 0,0, 10,1,0, 0,0), 0,0,0, 1,0, ex(1,2,0,0,0,0));
    step("f_add_x5",  mk(1, 1,1, 2,1,  5,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("g_add_x5",  mk(1, 1,1, 2,1,  5,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("h_use_both",mk(1, 5,1, 5,1, 11,1,0, 0,0), 0,0,0, 1,0, ex(1,1,1,0,0,0));
    // rs1 forwarding suppressed by pc source; rs2 still forwards despite imm source.
    step("i_src_pc",  mk(1, 5,1, 5,1, 12,1,0, 1,1), 0,0,0, 1,0, ex(1,0,2,1,1,0));

    // x0 producer never forwards.
    step("j_wr_x0",   mk(1, 1,1, 2,1,  0,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));
    step("k_rd_x0",   mk(1, 0,1, 0,1, 13,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));

    // Load-use: one bubble, then the consumer forwards from MEM/WB.
    step("l_lw_x7",   mk(1, 1,1, 0,0,  7,1,1, 0,1), 0,0,0, 1,0, ex(1,0,0,0,1,0));
    step("m_lu_stall",mk(1, 3,1, 7,1, 14,1,0, 0,0), 0,0,0, 1,1, ex(0,0,0,0,0,1));
    step("m_lu_retry",mk(1, 3,1, 7,1, 14,1,0, 0,0), 0,0,0, 1,0, ex(1,0,2,0,0,1));

    // Redirect overrides the load-use hazard.
    step("n_lw_x7",   mk(1, 1,1, 0,0,  7,1,1, 0,1), 0,0,0, 1,0, ex(1,0,0,0,1,1));
    step("o_redirect",mk(1, 3,1, 7,1, 14,1,0, 0,0), 1,0,0, 1,0, ex(0,0,0,0,0,1));
    step("p_nop",     nop,                          0,0,0, 1,0, ex(0,0,0,0,0,1));

    // mem_stall freezes everything for three cycles during a load-use hazard.
    step("q_lw_x7",   mk(1, 1,1, 0,0,  7,1,1, 0,1), 0,0,0, 1,0, ex(1,0,0,0,1,1));
    for (int i = 0; i < 3; i++)
      step("r_memstall", mk(1, 7,1, 2,0, 15,1,0, 0,0), 0,1,0, 1,1, ex(1,0,0,0,1,1));
    step("r_release", mk(1, 7,1, 2,0, 15,1,0, 0,0), 0,0,0, 1,1, ex(0,0,0,0,0,2));
    step("r_retry",   mk(1, 7,1, 2,0, 15,1,0, 0,0), 0,0,0, 1,0, ex(1,2,0,0,0,2));

    // Reset while a load-use stall is pending discards all state.
    step("s_lw_x7",   mk(1, 1,1, 0,0,  7,1,1, 0,1), 0,0,0, 1,0, ex(1,0,0,0,1,2));
    step("t_rst",     mk(1, 7,1, 0,0, 16,1,0, 0,0), 0,0,1, 0,0, ex(0,0,0,0,0,0));
    step("t_after",   mk(1, 7,1, 0,0, 16,1,0, 0,0), 0,0,0, 1,0, ex(1,0,0,0,0,0));

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
